spi_pixel_transmit: RTL and testbench
=====================================

SPI_PIXEL_TRANSMIT -- requirements
Module: spi_pixel_transmit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter LINES, default 4, meaning the number of parallel data lines (cipo); DATA_WIDTH SHALL be a multiple of LINES.
REQ-003 The block SHALL have parameter CLK_DIV, default 5, meaning dclk half-period in clk_in cycles; minimum 2.
REQ-004 The block SHALL have parameter CS_GAP, default 4, meaning clk_in cycles of chip_sel_out high between words; minimum 1.
REQ-005 The block SHALL have port clk_in, input, 1 bit, the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 The block SHALL have port rst_in, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH bits, the pixel to send.
REQ-008 The block SHALL have port valid_in, input, 1 bit, qualifying data_in and last_in.
REQ-009 The block SHALL have port last_in, input, 1 bit, marking the final pixel of a frame.
REQ-010 The block SHALL have port ready_out, output, 1 bit; a pixel is accepted on a cycle where valid_in and ready_out are both high.
REQ-011 The block SHALL have port chip_data_out, output, LINES bits, the serial data lines.
REQ-012 The block SHALL have port chip_clk_out, output, 1 bit, dclk.
REQ-013 The block SHALL have port chip_sel_out, output, 1 bit, an active-low word frame (cs).
REQ-014 The block SHALL have port final_pixel_out, output, 1 bit, the frame-end flag (spi_tlast).
REQ-015 The block SHALL have port busy_out, output, 1 bit, high in every state other than IDLE.

Function
REQ-016 The block SHALL define BEATS = DATA_WIDTH/LINES and transmit MSB-first, LINES bits per beat, with beat k carrying data[DATA_WIDTH-1-k*LINES -: LINES].
REQ-017 The block SHALL implement the state machine IDLE -> SHIFT -> GAP -> IDLE.
REQ-018 In IDLE, on acceptance, the block SHALL capture data_in and last_in and enter SHIFT on the next cycle.
REQ-019 On SHIFT entry, chip_sel_out SHALL be 0, chip_clk_out 0, chip_data_out = beat 0, and final_pixel_out = captured last, all registered with 1-cycle latency from acceptance.
REQ-020 Within SHIFT, chip_clk_out SHALL toggle every CLK_DIV cycles, producing BEATS rising edges, and chip_data_out SHALL change only on a falling edge (setup and hold of CLK_DIV cycles about each rising edge).
REQ-021 SHIFT SHALL last exactly 2*BEATS*CLK_DIV cycles, ending with dclk low, after which the block enters GAP with chip_sel_out=1 and chip_data_out=0.
REQ-022 final_pixel_out SHALL stay constant for the whole word and clear on GAP entry.
REQ-023 GAP SHALL last CS_GAP cycles, then return to IDLE.
REQ-024 chip_clk_out SHALL be 0 whenever chip_sel_out is 1.
REQ-025 valid_in dropping while the block is not ready SHALL have no effect; data is never taken without a handshake.
REQ-026 Back-to-back pixels SHALL produce words separated by exactly CS_GAP cycles of cs high when the next pixel is already valid.

Reset
REQ-027 While rst_in is high, the block SHALL hold state=IDLE, chip_sel_out=1, chip_clk_out=0, chip_data_out=0, final_pixel_out=0, ready_out=0, and busy_out=0.
REQ-028 Assertion of rst_in mid-word SHALL abort the word immediately (cs high, asynchronously); the partial pixel SHALL be discarded and never retransmitted.
REQ-029 ready_out SHALL go high on the first clock edge after rst_in deasserts.

Configuration
REQ-030 With SPI_TX_SKID_EN defined, a one-entry holding register SHALL be included: ready_out is high while the holding register is empty (including during SHIFT and GAP), a pixel held there starts SHIFT on the cycle GAP ends, and reset SHALL clear the holding register.
REQ-031 Without SPI_TX_SKID_EN, ready_out SHALL be high only in IDLE, so the inter-word spacing is CS_GAP+1 cycles under continuous valid.

Verification
REQ-032 The bench SHALL cover: defaults, send 8'hA5 -> cs low for 20 cycles, nibbles 4'hA then 4'h5 sampled on dclk rising edges, final_pixel_out=0.
REQ-033 The bench SHALL cover: send 8'h3C with last_in=1 -> final_pixel_out=1 for all 20 cs-low cycles, 0 in GAP.
REQ-034 The bench SHALL cover: continuous valid of 3 pixels without the macro -> cs-high gaps of 5 cycles; with SPI_TX_SKID_EN -> 4 cycles.
REQ-035 The bench SHALL cover: rst_in pulse at cycle 7 of a word -> cs high and dclk low immediately, ready_out high 1 cycle after release, no further beats.
REQ-036 The bench SHALL cover: LINES=2, DATA_WIDTH=8, CLK_DIV=2 with 8'hC6 -> 4 beats 2'b11,00,01,10, cs low for 16 cycles.
REQ-037 The bench SHALL cover: loopback of 320x180 random pixels into the 4-line receiver with the 2-FF synchronizers -> all pixels match and exactly one final pixel.

Source files
------------

// File: rtl/spi_pixel_transmit.sv
// spi_pixel_transmit: serialises one pixel per chip-select frame over LINES
// data lines, MSB beat first, with a divided data clock (dclk) and a fixed
// chip-select high gap between words.
// Optional build macro: SPI_TX_SKID_EN adds a one-entry holding register so
// the next pixel can be accepted while the current word is still shifting.
//
// state | meaning
// IDLE  | cs high, waiting for a pixel handshake
// SHIFT | cs low, dclk toggling, beats presented on chip_data_out
// GAP   | cs high, dclk low, enforcing the inter-word spacing
module spi_pixel_transmit #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 4,
  parameter int CLK_DIV    = 5,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  last_in,
  output logic                  ready_out,
  output logic [LINES-1:0]      chip_data_out,
  output logic                  chip_clk_out,
  output logic                  chip_sel_out,
  output logic                  final_pixel_out,
  output logic                  busy_out
);

  localparam int BEATS  = DATA_WIDTH / LINES;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int HALF_W = $clog2(2 * BEATS + 1);
  localparam int GAP_W  = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(2 * BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic [GAP_W-1:0]      gap_cnt;

  logic                  accept;
  logic                  gap_done;
  logic                  start;
  logic [DATA_WIDTH-1:0] start_data;
  logic                  start_last;
  logic                  ready_next;

  assign accept   = valid_in & ready_out;
  assign gap_done = (state == GAP) && (gap_cnt == '0);

`ifdef SPI_TX_SKID_EN
  logic                  hold_full;
  logic                  hold_full_next;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_last;

  // Pick the word to launch: a held pixel has priority at the end of GAP,
  // otherwise a live handshake in IDLE or on the last GAP cycle goes straight in.
  always_comb begin
    start          = 1'b0;
    start_data     = data_in;
    start_last     = last_in;
    hold_full_next = hold_full;
    if (state == IDLE && accept) begin
      start = 1'b1;
    end else if (gap_done && hold_full) begin
      start          = 1'b1;
      start_data     = hold_data;
      start_last     = hold_last;
      hold_full_next = 1'b0;
    end else if (gap_done && accept) begin
      start = 1'b1;
    end else if (accept) begin
      hold_full_next = 1'b1;
    end
    ready_next = ~hold_full_next;
  end

  // Holding register: filled by a handshake that cannot launch immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else begin
      hold_full <= hold_full_next;
      if (accept && !start) begin
        hold_data <= data_in;
        hold_last <= last_in;
      end
    end
  end
`else
  // Without the holding register a word can only be launched from IDLE.
  always_comb begin
    start      = (state == IDLE) && accept;
    start_data = data_in;
    start_last = last_in;
    ready_next = ((state == IDLE) && !accept) || gap_done;
  end
`endif

  // Main sequencer: word framing, dclk generation, beat shifting and gap timing.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      ready_out       <= 1'b0;
      busy_out        <= 1'b0;
      chip_sel_out    <= 1'b1;
      chip_clk_out    <= 1'b0;
      chip_data_out   <= '0;
      final_pixel_out <= 1'b0;
      shift_q         <= '0;
      div_cnt         <= '0;
      half_cnt        <= '0;
      gap_cnt         <= '0;
    end else begin
      ready_out <= ready_next;
      if (start) begin
        state           <= SHIFT;
        busy_out        <= 1'b1;
        chip_sel_out    <= 1'b0;
        chip_clk_out    <= 1'b0;
        chip_data_out   <= start_data[DATA_WIDTH-1 -: LINES];
        shift_q         <= start_data << LINES;
        final_pixel_out <= start_last;
        div_cnt         <= DIV_LOAD;
        half_cnt        <= HALF_LOAD;
      end else begin
        case (state)
          SHIFT: begin
            if (div_cnt == '0) begin
              div_cnt <= DIV_LOAD;
              if (half_cnt == '0) begin
                // Last high half just finished: close the word with dclk low.
                state           <= GAP;
                chip_sel_out    <= 1'b1;
                chip_clk_out    <= 1'b0;
                chip_data_out   <= '0;
                final_pixel_out <= 1'b0;
                gap_cnt         <= GAP_LOAD;
              end else begin
                half_cnt     <= half_cnt - 1'b1;
                chip_clk_out <= ~chip_clk_out;
                // Data only moves on the falling edge, giving a full half
                // period of setup and hold around every rising edge.
                if (chip_clk_out) begin
                  chip_data_out <= shift_q[DATA_WIDTH-1 -: LINES];
                  shift_q       <= shift_q << LINES;
                end
              end
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == '0) begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_pixel_transmit.sv
// Scoreboard bench for spi_pixel_transmit: stimulus pushes expected words,
// monitors on the serial side pop and compare. A second instance covers the
// 2-line / CLK_DIV=2 configuration; a synchronizing receiver model checks
// loopback of a small random frame.
module tb_spi_pixel_transmit;

  typedef struct {
    logic [7:0] word;
    int         beats;
    int         cnt;
    logic       last;
  } exp_t;

`ifdef SPI_TX_SKID_EN
  localparam int GAP_EXP = 4;
`else
  localparam int GAP_EXP = 5;
`endif
  localparam int LB_PIXELS = 48;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0, a_last = 1'b0;
  logic       a_ready, a_dclk, a_cs, a_final, a_busy;
  logic [3:0] a_sdata;

  spi_pixel_transmit dut_a (
    .clk_in(clk), .rst_in(rst), .data_in(a_data), .valid_in(a_valid),
    .last_in(a_last), .ready_out(a_ready), .chip_data_out(a_sdata),
    .chip_clk_out(a_dclk), .chip_sel_out(a_cs), .final_pixel_out(a_final),
    .busy_out(a_busy)
  );

  // Two-line instance
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0, b_last = 1'b0;
  logic       b_ready, b_dclk, b_cs, b_final, b_busy;
  logic [1:0] b_sdata;

  spi_pixel_transmit #(.DATA_WIDTH(8), .LINES(2), .CLK_DIV(2), .CS_GAP(4)) dut_b (
    .clk_in(clk), .rst_in(rst), .data_in(b_data), .valid_in(b_valid),
    .last_in(b_last), .ready_out(b_ready), .chip_data_out(b_sdata),
    .chip_clk_out(b_dclk), .chip_sel_out(b_cs), .final_pixel_out(b_final),
    .busy_out(b_busy)
  );

  exp_t exp_q[$];
  int   gap_q[$];
  exp_t expb_q[$];
  logic [8:0] lb_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor for the default instance
  logic       a_prev_cs = 1'b1, a_prev_dclk = 1'b0, a_last0 = 1'b0, a_last_ok = 1'b1;
  logic [7:0] a_word = '0;
  int         a_cnt = 0, a_beats = 0, a_gap = 0;
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (!a_cs) begin
      if (a_prev_cs) begin
        check("a_word_expected", 32'(exp_q.size() != 0), 32'd1);
        check("a_busy_in_word", 32'(a_busy), 32'd1);
        if (gap_q.size() != 0) begin
          g = gap_q.pop_front();
          if (g >= 0) check("a_cs_gap", 32'(a_gap), 32'(g));
        end
        a_cnt = 0; a_word = '0; a_beats = 0; a_last0 = a_final; a_last_ok = 1'b1;
      end
      a_cnt++;
      if (a_final !== a_last0) a_last_ok = 1'b0;
      if (a_dclk && !a_prev_dclk) begin
        a_word = {a_word[3:0], a_sdata};
        a_beats++;
      end
    end else begin
      if (!a_prev_cs) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("a_data", 32'(a_word), 32'(e.word));
          check("a_beats", 32'(a_beats), 32'(e.beats));
          check("a_cs_low_cycles", 32'(a_cnt), 32'(e.cnt));
          check("a_final_value", 32'(a_last0), 32'(e.last));
          check("a_final_stable", 32'(a_last_ok), 32'd1);
        end
        a_gap = 0;
      end
      a_gap++;
      if (a_dclk !== 1'b0 || a_sdata !== 4'h0 || a_final !== 1'b0)
        check("a_lines_idle", {a_final, a_sdata, a_dclk}, 32'd0);
    end
    a_prev_cs   = a_cs;
    a_prev_dclk = a_dclk;
  end

  // Monitor for the two-line instance
  logic       b_prev_cs = 1'b1, b_prev_dclk = 1'b0;
  logic [7:0] b_word = '0;
  int         b_cnt = 0, b_beats = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!b_cs) begin
      if (b_prev_cs) begin
        check("b_word_expected", 32'(expb_q.size() != 0), 32'd1);
        b_cnt = 0; b_word = '0; b_beats = 0;
      end
      b_cnt++;
      if (b_dclk && !b_prev_dclk) begin
        b_word = {b_word[5:0], b_sdata};
        b_beats++;
      end
    end else begin
      if (!b_prev_cs && expb_q.size() != 0) begin
        e = expb_q.pop_front();
        check("b_data", 32'(b_word), 32'(e.word));
        check("b_beats", 32'(b_beats), 32'(e.beats));
        check("b_cs_low_cycles", 32'(b_cnt), 32'(e.cnt));
      end
      if (b_dclk !== 1'b0) check("b_dclk_idle", 32'(b_dclk), 32'd0);
    end
    b_prev_cs   = b_cs;
    b_prev_dclk = b_dclk;
  end

  // Loopback receiver: 2-FF synchronizers into a separate sampling domain model
  logic [6:0] rx_s1, rx_s2, rx_s3;
  always @(posedge clk) begin
    rx_s1 <= {a_final, a_sdata, a_dclk, a_cs};
    rx_s2 <= rx_s1;
    rx_s3 <= rx_s2;
  end

  logic       lb_en = 1'b0;
  logic [7:0] rx_word = '0;
  logic       rx_last = 1'b0;
  int         rx_count = 0, rx_finals = 0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (lb_en) begin
      if (!rx_s2[0] && rx_s2[1] && !rx_s3[1]) begin
        rx_word = {rx_word[3:0], rx_s2[5:2]};
        rx_last = rx_s2[6];
      end
      if (rx_s2[0] && !rx_s3[0]) begin
        rx_count++;
        if (rx_last) rx_finals++;
        if (lb_q.size() == 0) begin
          check("lb_unexpected_word", 32'd1, 32'd0);
        end else begin
          e = lb_q.pop_front();
          check("lb_pixel", {23'd0, rx_last, rx_word}, {23'd0, e});
        end
      end
    end
  end

  task automatic send_a(input logic [7:0] d, input logic l, input int gap, input bit hold);
    int   n;
    exp_t e;
    a_data = d; a_last = l; a_valid = 1'b1; n = 0;
    while (!a_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!a_ready) begin
      check("a_ready_timeout", 32'(a_ready), 32'd1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = '{d, 2, 20, l};
    exp_q.push_back(e);
    gap_q.push_back(gap);
    #1;
    if (!hold) a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int   n;
    exp_t e;
    b_data = d; b_last = 1'b0; b_valid = 1'b1; n = 0;
    while (!b_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!b_ready) begin
      check("b_ready_timeout", 32'(b_ready), 32'd1);
      b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = '{d, 4, 16, 1'b0};
    expb_q.push_back(e);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || expb_q.size() != 0 || a_busy || b_busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) check("wait_idle_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [7:0] px;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(a_cs), 32'd1);
    check("rst_dclk", 32'(a_dclk), 32'd0);
    check("rst_data", 32'(a_sdata), 32'd0);
    check("rst_final", 32'(a_final), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;
    #1 check("ready_before_edge", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", 32'(a_ready), 32'd1);

    // Basic word and frame-end word
    send_a(8'hA5, 1'b0, -1, 1'b0);
    wait_idle();
    send_a(8'h3C, 1'b1, -1, 1'b0);
    wait_idle();

    // Continuous valid: three back-to-back pixels
    send_a(8'h11, 1'b0, -1, 1'b1);
    send_a(8'h22, 1'b0, GAP_EXP, 1'b1);
    send_a(8'h33, 1'b0, GAP_EXP, 1'b0);
    wait_idle();

`ifndef SPI_TX_SKID_EN
    // valid raised and dropped while not ready must not start a word
    send_a(8'h5A, 1'b0, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a_data = 8'hFF; a_valid = 1'b1;
    check("ready_low_in_shift", 32'(a_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 a_valid = 1'b0;
    wait_idle();
`endif

    // Reset at cycle 7 of a word: one beat (nibble A) seen, 7 cs-low cycles
    send_a(8'hA5, 1'b0, -1, 1'b0);
    e = exp_q.pop_back();
    e.word = 8'h0A; e.beats = 1; e.cnt = 7;
    exp_q.push_back(e);
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_cs_high", 32'(a_cs), 32'd1);
    check("abort_dclk_low", 32'(a_dclk), 32'd0);
    check("abort_ready_low", 32'(a_ready), 32'd0);
    check("abort_busy_low", 32'(a_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort_ready_before_edge", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    check("abort_ready_after_release", 32'(a_ready), 32'd1);
    repeat (40) @(negedge clk);
    wait_idle();

    // Two-line configuration
    send_b(8'hC6);
    wait_idle();

    // Loopback of a reduced random frame through the synchronizing receiver
    lb_en = 1'b1;
    for (int i = 0; i < LB_PIXELS; i++) begin
      px = 8'($urandom_range(0, 255));
      lb_q.push_back({(i == LB_PIXELS - 1), px});
      send_a(px, (i == LB_PIXELS - 1), (i == 0) ? -1 : GAP_EXP, (i != LB_PIXELS - 1));
    end
    wait_idle();
    lb_en = 1'b0;
    check("lb_pixel_count", 32'(rx_count), 32'(LB_PIXELS));
    check("lb_final_count", 32'(rx_finals), 32'd1);
    check("lb_queue_drained", 32'(lb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
